// File: rtl/csa_pkg.sv
// Shared definitions for the pipelined conditional-sum adder.
//   CSA_W / CSA_STAGES     : default operand width and register-stage count
//   csa_levels()           : ceil(log2(w)), the number of merge levels
//   csa_lvls_per_stage()   : upper bound on tree levels placed in one stage
//   csa_stage_of()         : stage index that evaluates a given tree level
//   csa_side_t             : per-beat control that travels beside the tree
package csa_pkg;

    localparam int CSA_W      = 16;
    localparam int CSA_STAGES = 2;

    function automatic int unsigned csa_levels(input int unsigned w);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < w; p = p << 1) begin
            r++;
        end
        return r;
    endfunction

    // Tree levels = leaf level + merge levels.
    function automatic int unsigned csa_lvls_per_stage(input int unsigned w, input int unsigned s);
        return (csa_levels(w) + 1 + s - 1) / s;
    endfunction

    // Spreads the levels evenly: every stage gets at least one level and
    // never more than csa_lvls_per_stage(), so exactly s-1 level boundaries
    // carry a register.
    function automatic int unsigned csa_stage_of(input int unsigned lvl, input int unsigned w,
                                                 input int unsigned s);
        return (lvl * s) / (csa_levels(w) + 1);
    endfunction

    localparam int unsigned CSA_LVLS_PER_STAGE = csa_lvls_per_stage(CSA_W, CSA_STAGES);

    typedef struct packed {
        logic vld;
        logic amsb;   // a[W-1]
        logic bmsb;   // possibly inverted b[W-1]
        logic chain;
        logic sub;
        logic cin;
    } csa_side_t;

endpackage

// File: rtl/csa_merge.sv
// One conditional-sum tree node: joins two H-bit blocks into a 2H-bit block,
// keeping both carry-in variants.
//   lo_*/hi_* : lower/upper half sums and carry-outs for carry-in 0 and 1
//   s0,c0     : merged sum/carry assuming block carry-in 0
//   s1,c1     : merged sum/carry assuming block carry-in 1
module csa_merge
    import csa_pkg::*;
#(
    parameter int H = 1
) (
    input  logic [H-1:0]   lo_s0,
    input  logic [H-1:0]   lo_s1,
    input  logic           lo_c0,
    input  logic           lo_c1,
    input  logic [H-1:0]   hi_s0,
    input  logic [H-1:0]   hi_s1,
    input  logic           hi_c0,
    input  logic           hi_c1,
    output logic [2*H-1:0] s0,
    output logic [2*H-1:0] s1,
    output logic           c0,
    output logic           c1
);

    assign s0 = {(lo_c0 ? hi_s1 : hi_s0), lo_s0};
    assign c0 = lo_c0 ? hi_c1 : hi_c0;
    assign s1 = {(lo_c1 ? hi_s1 : hi_s0), lo_s1};
    assign c1 = lo_c1 ? hi_c1 : hi_c0;

endmodule

// File: rtl/pipelined_csa_adder.sv
// Pipelined conditional-sum adder with add/subtract and multi-word chaining.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand beat handshake (a, b, cin, sub, chain)
//   out_valid/out_ready : result beat handshake (sum, cout, ovf)
// The tree keeps both carry-in variants until the final stage, where the
// real carry (cin, 1 for subtract, or the previous beat's cout) picks one.
// Any stall at the output freezes the whole pipeline.
module pipelined_csa_adder
    import csa_pkg::*;
#(
    parameter int W      = CSA_W,
    parameter int STAGES = CSA_STAGES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    input  logic         chain,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int L = int'(csa_levels(W));

    logic         en;
    logic         last_cout;
    logic [W-1:0] bx;
    csa_side_t    in_sd;

    assign in_ready = !(out_valid && !out_ready);
    assign en       = in_ready;
    assign bx       = sub ? ~b : b;
    assign in_sd    = '{vld: in_valid, amsb: a[W-1], bmsb: bx[W-1],
                        chain: chain, sub: sub, cin: cin};

    for (genvar j = 0; j <= L; j++) begin : g_lvl
        localparam int NB  = W >> j;
        localparam bit REG = (j < L) &&
            (csa_stage_of(j + 1, W, STAGES) != csa_stage_of(j, W, STAGES));

        logic [W-1:0]  s0, s1, q_s0, q_s1;
        logic [NB-1:0] c0, c1, q_c0, q_c1;
        csa_side_t     sd, q_sd;

        if (j == 0) begin : g_leaf
            assign sd = in_sd;
            assign s0 = a ^ bx;
            assign c0 = a & bx;
            assign s1 = ~(a ^ bx);
            assign c1 = a | bx;
        end else begin : g_merge
            localparam int H = 1 << (j - 1);
            assign sd = g_lvl[j-1].q_sd;
            for (genvar k = 0; k < NB; k++) begin : g_node
                csa_merge #(.H(H)) u_merge (
                    .lo_s0 (g_lvl[j-1].q_s0[2*k*H +: H]),
                    .lo_s1 (g_lvl[j-1].q_s1[2*k*H +: H]),
                    .lo_c0 (g_lvl[j-1].q_c0[2*k]),
                    .lo_c1 (g_lvl[j-1].q_c1[2*k]),
                    .hi_s0 (g_lvl[j-1].q_s0[(2*k+1)*H +: H]),
                    .hi_s1 (g_lvl[j-1].q_s1[(2*k+1)*H +: H]),
                    .hi_c0 (g_lvl[j-1].q_c0[2*k+1]),
                    .hi_c1 (g_lvl[j-1].q_c1[2*k+1]),
                    .s0    (s0[k*2*H +: 2*H]),
                    .s1    (s1[k*2*H +: 2*H]),
                    .c0    (c0[k]),
                    .c1    (c1[k])
                );
            end
        end

        if (REG) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_sd <= '0;
                end else if (en) begin
                    q_sd <= sd;
                end
            end
            always_ff @(posedge clk) begin
                if (en) begin
                    q_s0 <= s0;
                    q_s1 <= s1;
                    q_c0 <= c0;
                    q_c1 <= c1;
                end
            end
        end else begin : g_wire
            assign q_sd = sd;
            assign q_s0 = s0;
            assign q_s1 = s1;
            assign q_c0 = c0;
            assign q_c1 = c1;
        end
    end

    csa_side_t    fs;
    logic         prev_c, carry, cout_n, ovf_n;
    logic [W-1:0] sum_n;

    assign fs = g_lvl[L].q_sd;

    // When the pipeline advances with a result still in the output register,
    // that result is being handed off this very edge, so its cout is the
    // predecessor carry; this lets back-to-back chained beats run bubble-free.
    always_comb begin
        prev_c = out_valid ? cout : last_cout;
        carry  = fs.chain ? prev_c : (fs.sub | fs.cin);
        sum_n  = carry ? g_lvl[L].q_s1 : g_lvl[L].q_s0;
        cout_n = carry ? g_lvl[L].q_c1[0] : g_lvl[L].q_c0[0];
        ovf_n  = (fs.amsb == fs.bmsb) && (sum_n[W-1] != fs.amsb);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            sum       <= '0;
            cout      <= '0;
            ovf       <= '0;
            last_cout <= '0;
        end else begin
            if (out_valid && out_ready) begin
                last_cout <= cout;
            end
            if (en) begin
                out_valid <= fs.vld;
                if (fs.vld) begin
                    sum  <= sum_n;
                    cout <= cout_n;
                    ovf  <= ovf_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_csa_adder.sv
module tb_pipelined_csa_adder;

    localparam int W      = 16;
    localparam int STAGES = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         chain = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    pipelined_csa_adder #(.W(W), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .chain     (chain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a, b;
        logic         cin, sub, chain;
        logic [W-1:0] sum;
        logic         cout, ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout, ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;
    logic m_last = 1'b0;
    bit   rnd_rdy = 1'b0;
    exp_t got;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic exp_t model(input vec_t v, input logic last);
        exp_t         r;
        logic [W:0]   t;
        logic [W-1:0] bb;
        logic         c;
        bb     = v.sub ? ~v.b : v.b;
        c      = v.chain ? last : (v.sub | v.cin);
        t      = {1'b0, v.a} + {1'b0, bb} + (W+1)'(c);
        r.sum  = t[W-1:0];
        r.cout = t[W];
        r.ovf  = (v.a[W-1] == bb[W-1]) && (t[W-1] != v.a[W-1]);
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input vec_t v, input bit use_model);
        int unsigned g;
        exp_t        e;
        g        = 0;
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        sub      = v.sub;
        chain    = v.chain;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            g++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: actual in_ready=0 required 1 within 50 cycles");
        end else begin
            if (use_model) begin
                e = model(v, m_last);
            end else begin
                e.sum  = v.sum;
                e.cout = v.cout;
                e.ovf  = v.ovf;
            end
            m_last = e.cout;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned g;
        g = 0;
        while (sb.size() != 0 && g < 400) begin
            @(negedge clk);
            g++;
        end
        check("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: actual sum %0h required no beat", sum);
                end else begin
                    got = sb.pop_front();
                    n_out++;
                    check("sum", sum, got.sum);
                    check("cout", cout, got.cout);
                    check("ovf", ovf, got.ovf);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[12];
        vec_t v;
        int   n0;

        vt[0]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, 16'h5556, 1'b0, 1'b0};
        vt[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[2]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vt[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vt[5]  = '{16'h0003, 16'h0003, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[6]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
        vt[8]  = '{16'h0010, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
        vt[9]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
        vt[10] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[11] = '{16'h00FF, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0};

        // Reset state
        #1;
        rst_n = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Latency: FFFF + 0001
        v = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        send(v, 1'b0);
        check("lat_not_early", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_valid_at_2", out_valid, 1);
        drain();

        // Table vectors, back-to-back
        for (int i = 0; i < 12; i++) begin
            send(vt[i], 1'b0);
        end
        drain();

        // Bubble between a carry-producing beat and a chained beat
        v = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        send(v, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        v = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
        send(v, 1'b0);
        drain();

        // Stall: three beats, out_ready low for 5 cycles
        n0 = n_out;
        out_ready = 1'b0;
        v = '{16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
        send(v, 1'b0);
        v = '{16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0};
        send(v, 1'b0);
        fork
            begin
                v = '{16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0};
                send(v, 1'b0);
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_out_valid", out_valid, 1);
                    check("stall_sum_hold", sum, 16'h0003);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_beat_count", n_out - n0, 3);

        // Reset with beats in flight after a carry-out of 1
        v = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        send(v, 1'b0);
        drain();
        send(v, 1'b0);
        send(v, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_flight_out_valid", out_valid, 0);
        check("rst_flight_in_ready", in_ready, 1);
        sb.delete();
        m_last = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v = '{16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0};
        send(v, 1'b0);
        drain();

        // Random beats and handshakes against the behavioural model
        rnd_rdy = 1'b1;
        for (int unsigned i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            v.a     = W'($urandom);
            v.b     = W'($urandom);
            v.cin   = 1'($urandom_range(0, 1));
            v.sub   = 1'($urandom_range(0, 1));
            v.chain = ($urandom_range(0, 2) == 0);
            v.sum   = '0;
            v.cout  = 1'b0;
            v.ovf   = 1'b0;
            send(v, 1'b1);
        end
        rnd_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipelined_csa_adder.md
PIPELINED_CSA_ADDER -- requirements
Module: pipelined_csa_adder

Interface
REQ-001 Parameter W, default 16: operand width; power of two, 2..64.
REQ-002 Parameter STAGES, default 2: register stages, 1..log2(W)+1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts the beat this cycle.
REQ-007 a, b  input  W  operands.
REQ-008 cin  input  1  carry-in, used when chain=0 and sub=0.
REQ-009 sub  input  1  1 = compute a + ~b + carry (subtract).
REQ-010 chain  input  1  1 = carry-in is the cout of the previous output beat (multi-word add).
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 sum  output  W  result.
REQ-014 cout  output  1  carry-out.
REQ-015 ovf  output  1  two's-complement overflow.

Function
REQ-016 Input handshake when in_valid && in_ready; output handshake when out_valid && out_ready.
REQ-017 in_ready SHALL equal !(out_valid && !out_ready); while it is 0 the whole pipeline holds (global stall) and outputs stay stable.
REQ-018 Latency SHALL be exactly STAGES cycles from input handshake to out_valid when there is no stall; full throughput is 1 beat per cycle.
REQ-019 The datapath SHALL be a conditional-sum tree: level 0 computes per-bit (s0,c0,s1,c1) for carry-in 0 and 1; each of log2(W) merge levels doubles block width by muxing the upper half's pair on the lower half's carry.
REQ-020 b SHALL be inverted at the input when sub=1; the tree carries both carry-in variants to the last stage.
REQ-021 Carry selection SHALL happen in the last stage: effective carry = chain ? last_cout : (sub ? 1 : cin); chain, sub and cin travel with the beat.
REQ-022 last_cout SHALL update to cout on every output handshake only; a back-to-back chained beat therefore uses its predecessor's carry without a bubble.
REQ-023 ovf = (a[W-1] == b'[W-1]) && (sum[W-1] != a[W-1]), with b' the possibly inverted b.
REQ-024 Merge levels SHALL be spread over the stages, with at most ceil((log2(W)+1)/STAGES) levels per stage; the output register is the final stage.
REQ-025 Bubbles (in_valid=0) SHALL propagate as invalid slots and do not disturb last_cout.
REQ-026 A chained beat issued first after reset SHALL use carry 0.

Reset
REQ-027 rst_n low SHALL asynchronously clear every stage valid bit, out_valid, sum, cout, ovf and last_cout to 0; in-flight beats are discarded.
REQ-028 in_ready SHALL be 1 during and after reset while out_valid=0.

Structure
REQ-029 Package csa_pkg SHALL hold the default W, a clog2-style level-count function and the per-stage level-count constant.
REQ-030 One sub-module, csa_merge (parametrised half-width, two-variant merge mux), SHALL be instantiated per tree node through generate loops.

Verification
REQ-031 W=16, STAGES=2: a=0xFFFF, b=0x0001, cin=0 -> two cycles later sum=0x0000, cout=1, ovf=0.
REQ-032 Chain: beat 1 a=0xFFFF, b=0x0001, chain=0; beat 2 next cycle a=0, b=0, chain=1 -> sums 0x0000 then 0x0001, couts 1 then 0.
REQ-033 Sub: a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-034 Three beats issued, out_ready held 0 for 5 cycles -> in_ready=0 while stalled; all three delivered in order with no loss or duplication.
REQ-035 rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately; next chain=1 beat 0x0001+0x0001 -> sum=0x0002.
REQ-036 Random beats with random handshakes vs a behavioural model, for W in {8,16,32} and every legal STAGES.
